// File: rtl/process_controller.sv
// Run-control stage for a cluster of matrix-multiplication cores.
// Sequences START -> RUN -> DONE for all cores, collects per-core completion,
// counts RUN cycles and optionally flags a timeout. All outputs are registered.
module process_controller #(
  parameter int NUM_CORES    = 2,
  parameter int START_CYCLES = 2,
  parameter int CYCLE_W      = 32,
  parameter int TIMEOUT      = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clear,
  input  logic [NUM_CORES-1:0]   end_process,
  output logic [2*NUM_CORES-1:0] status,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [NUM_CORES-1:0]   core_done,
  output logic [CYCLE_W-1:0]     cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE,
    S_ERROR
  } state_t;

  // Start counter only needs to reach START_CYCLES-1.
  localparam int SCNT_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam logic [SCNT_W-1:0] START_LAST = SCNT_W'(START_CYCLES - 1);
  // TIMEOUT must fit in CYCLE_W bits; zero disables the check entirely.
  localparam logic [CYCLE_W-1:0] TIMEOUT_LAST = (TIMEOUT == 0) ? '0 : CYCLE_W'(TIMEOUT - 1);
  localparam logic [CYCLE_W-1:0] COUNT_MAX = '1;

  state_t                   state_q, state_d;
  logic [SCNT_W-1:0]        start_cnt, start_cnt_d;
  logic [NUM_CORES-1:0]     core_done_d;
  logic [CYCLE_W-1:0]       cycle_count_d;
  logic [CYCLE_W-1:0]       count_inc;
  logic [2*NUM_CORES-1:0]   status_d;
  logic                     all_done;
  logic                     timeout_hit;

  // Completion counts the current cycle's end_process so the last core's flag
  // moves the FSM to DONE on the very next edge.
  assign all_done    = &(core_done | end_process);
  assign count_inc   = (cycle_count == COUNT_MAX) ? cycle_count : cycle_count + CYCLE_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cycle_count == TIMEOUT_LAST);

  // Next-state logic: clear beats completion, completion beats timeout.
  always_comb begin
    state_d       = state_q;
    start_cnt_d   = start_cnt;
    core_done_d   = core_done;
    cycle_count_d = cycle_count;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d       = S_START;
          start_cnt_d   = '0;
          core_done_d   = '0;
          cycle_count_d = '0;
        end
      end
      S_START: begin
        if (clear) begin
          state_d = S_IDLE;
        end else if (start_cnt == START_LAST) begin
          state_d = S_RUN;
        end else begin
          start_cnt_d = start_cnt + SCNT_W'(1);
        end
      end
      S_RUN: begin
        if (clear) begin
          state_d = S_IDLE;
        end else begin
          core_done_d   = core_done | end_process;
          cycle_count_d = count_inc;
          if (all_done) begin
            state_d = S_DONE;
          end else if (timeout_hit) begin
            state_d = S_ERROR;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (clear) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status each core will see after the edge, derived from the next state so
  // a finishing core reads HALT on the same edge its core_done bit sets.
  always_comb begin
    status_d = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      case (state_d)
        S_START: status_d[2*n +: 2] = 2'b01;
        S_RUN:   status_d[2*n +: 2] = core_done_d[n] ? 2'b11 : 2'b10;
        S_DONE:  status_d[2*n +: 2] = 2'b11;
        default: status_d[2*n +: 2] = 2'b00;
      endcase
    end
  end

  // State and registered outputs; reset drops every core back to IDLE at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      start_cnt   <= '0;
      core_done   <= '0;
      cycle_count <= '0;
      status      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_cnt   <= start_cnt_d;
      core_done   <= core_done_d;
      cycle_count <= cycle_count_d;
      status      <= status_d;
      busy        <= (state_d == S_START) || (state_d == S_RUN);
      done        <= (state_d == S_DONE);
      error       <= (state_d == S_ERROR);
    end
  end

endmodule

// File: tb/tb_process_controller.sv
// Directed self-checking bench for process_controller.
// Main instance: NUM_CORES=2, START_CYCLES=2, TIMEOUT=16, CYCLE_W=32.
// Second instance: TIMEOUT=0, CYCLE_W=4 for the saturation scenario.
module tb_process_controller;

  logic        clock;
  logic        reset;
  logic        start, clear;
  logic [1:0]  end_process;
  logic [3:0]  status;
  logic        busy, done, error;
  logic [1:0]  core_done;
  logic [31:0] cycle_count;

  logic        start2, clear2;
  logic [1:0]  end_process2;
  logic [3:0]  status2;
  logic        busy2, done2, error2;
  logic [1:0]  core_done2;
  logic [3:0]  cycle_count2;

  int errors = 0;
  int checks = 0;

  process_controller #(.NUM_CORES(2), .START_CYCLES(2), .CYCLE_W(32), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .start(start), .clear(clear),
    .end_process(end_process), .status(status), .busy(busy), .done(done),
    .error(error), .core_done(core_done), .cycle_count(cycle_count)
  );

  process_controller #(.NUM_CORES(2), .START_CYCLES(2), .CYCLE_W(4), .TIMEOUT(0)) dut_sat (
    .clock(clock), .reset(reset), .start(start2), .clear(clear2),
    .end_process(end_process2), .status(status2), .busy(busy2), .done(done2),
    .error(error2), .core_done(core_done2), .cycle_count(cycle_count2)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse start for one edge, leaving the DUT in its first START cycle.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; clear = 0; end_process = 0;
    start2 = 0; clear2 = 0; end_process2 = 0;
    #2;
    checks++;
    if (status !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: status=%b busy=%b done=%b error=%b, expected 0000/0/0/0", status, busy, done, error);
    end
    checks++;
    if (core_done !== 2'b00 || cycle_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL reset_counts: core_done=%b cycle_count=%0d, expected 00/0", core_done, cycle_count);
    end
    tick();
    reset = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (status !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_clear: status=%b busy=%b, expected 0000/0", status, busy);
    end
  endtask

  task automatic test_normal_run();
    pulse_start();
    checks++;
    if (status !== 4'b0101 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_cycle0: status=%b busy=%b, expected 0101/1", status, busy);
    end
    tick();
    checks++;
    if (status !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL start_cycle1: status=%b, expected 0101", status);
    end
    tick();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (status !== ((k <= 5) ? 4'b1010 : 4'b1011) || cycle_count !== k || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL run_cycle%0d: status=%b count=%0d busy=%b", k, status, cycle_count, busy);
      end
      end_process = {(k == 9), (k == 5)};
      tick();
    end
    end_process = 2'b00;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || status !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL normal_done: done=%b busy=%b status=%b, expected 1/0/1111", done, busy, status);
    end
    checks++;
    if (cycle_count !== 32'd10 || core_done !== 2'b11) begin
      errors++;
      $display("[TB] FAIL normal_count: cycle_count=%0d core_done=%b, expected 10/11", cycle_count, core_done);
    end
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || status !== 4'b1111 || cycle_count !== 32'd10 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_ignores_start: done=%b status=%b count=%0d busy=%b", done, status, cycle_count, busy);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (done !== 1'b0 || status !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL normal_clear: done=%b status=%b busy=%b, expected 0/0000/0", done, status, busy);
    end
  endtask

  task automatic test_simultaneous();
    pulse_start();
    checks++;
    if (core_done !== 2'b00 || cycle_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL start_clears: core_done=%b count=%0d, expected 00/0", core_done, cycle_count);
    end
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      end_process = (k == 3) ? 2'b11 : 2'b00;
      tick();
    end
    end_process = 2'b00;
    checks++;
    if (done !== 1'b1 || core_done !== 2'b11 || cycle_count !== 32'd4 || status !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL simultaneous: done=%b core_done=%b count=%0d status=%b, expected 1/11/4/1111", done, core_done, cycle_count, status);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_timeout();
    pulse_start();
    tick();
    tick();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (error !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL timeout_early%0d: error=%b busy=%b, expected 0/1", k, error, busy);
      end
      tick();
    end
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || status !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL timeout_flags: error=%b busy=%b done=%b status=%b, expected 1/0/0/0000", error, busy, done, status);
    end
    checks++;
    if (cycle_count !== 32'd16) begin
      errors++;
      $display("[TB] FAIL timeout_count: cycle_count=%0d, expected 16", cycle_count);
    end
    tick();
    checks++;
    if (error !== 1'b1 || cycle_count !== 32'd16) begin
      errors++;
      $display("[TB] FAIL error_hold: error=%b count=%0d, expected 1/16", error, cycle_count);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (error !== 1'b0 || status !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL timeout_clear: error=%b status=%b, expected 0/0000", error, status);
    end
  endtask

  task automatic test_abort();
    end_process = 2'b11;
    tick();
    checks++;
    if (busy !== 1'b0 || status !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL idle_ignores_end: busy=%b status=%b, expected 0/0000", busy, status);
    end
    end_process = 2'b00;
    pulse_start();
    end_process = 2'b11;
    tick();
    tick();
    end_process = 2'b00;
    checks++;
    if (core_done !== 2'b00 || status !== 4'b1010 || cycle_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL start_ignores_end: core_done=%b status=%b count=%0d, expected 00/1010/0", core_done, status, cycle_count);
    end
    tick();
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (status !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || cycle_count !== 32'd3) begin
      errors++;
      $display("[TB] FAIL run_abort: status=%b busy=%b done=%b count=%0d, expected 0000/0/0/3", status, busy, done, cycle_count);
    end
  endtask

  task automatic test_async_reset();
    pulse_start();
    for (int k = 0; k < 6; k++) tick();
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (status !== 4'b0000 || busy !== 1'b0 || cycle_count !== 32'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: status=%b busy=%b count=%0d, expected 0000/0/0", status, busy, cycle_count);
    end
    #1;
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (status !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: status=%b busy=%b done=%b error=%b", status, busy, done, error);
    end
  endtask

  task automatic test_saturate();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 20; k++) tick();
    checks++;
    if (cycle_count2 !== 4'd15 || error2 !== 1'b0 || busy2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL saturate_run: count=%0d error=%b busy=%b, expected 15/0/1", cycle_count2, error2, busy2);
    end
    end_process2 = 2'b11;
    tick();
    end_process2 = 2'b00;
    checks++;
    if (done2 !== 1'b1 || error2 !== 1'b0 || cycle_count2 !== 4'd15 || status2 !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL saturate_done: done=%b error=%b count=%0d status=%b, expected 1/0/15/1111", done2, error2, cycle_count2, status2);
    end
    clear2 = 1'b1;
    tick();
    clear2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_simultaneous();
    test_timeout();
    test_abort();
    test_async_reset();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/process_controller.md
Name: process_controller

Overview:
- Run-control stage that sits directly upstream of the matrix-multiplication cores.
- Drives each core's 2-bit status input and collects each core's end_process output.
- Sequences one start / run / completion cycle for all cores, measures run time in clock cycles and flags a timeout.
- The top level instantiates one controller per core cluster; the host side uses start/clear/done.

Parameters:
- NUM_CORES, 2, number of cores controlled (1..8).
- START_CYCLES, 2, cycles status is held at START so cores reset PC/DAR before running (≥1).
- CYCLE_W, 32, width of the run-cycle counter.
- TIMEOUT, 0, run-cycle limit; 0 disables timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  host start request, sampled only in IDLE.
- clear  in  1  host acknowledge/abort.
- end_process  in  NUM_CORES  per-core completion flag, bit n from core n.
- status  out  2*NUM_CORES  per-core status, bits [2n+1:2n] to core n.
- busy  out  1  high in START and RUN.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.
- core_done  out  NUM_CORES  sticky per-core completion.
- cycle_count  out  CYCLE_W  RUN cycles of the current/last job.

Behaviour:
- One clock. Reset is asynchronous and active-high; all outputs are registered.
- Status encoding per core:
  - 2'b00 IDLE: core waits.
  - 2'b01 START: core initialises PC/DAR.
  - 2'b10 RUN: core executes.
  - 2'b11 HALT: completion acknowledged, core holds.
- Reset values: FSM=IDLE, status=0, busy=0, done=0, error=0, core_done=0, cycle_count=0, start counter=0.
- IDLE:
  - start=1 → START. On entry, cycle_count=0, core_done=0, start counter=0.
  - clear has no effect.
- START:
  - All cores get status 01 for exactly START_CYCLES cycles, then → RUN.
  - end_process is ignored.
  - clear=1 → IDLE (abort).
- RUN:
  - Cores with core_done[n]=0 get status 10; cores with core_done[n]=1 get status 11.
  - end_process[n]=1 sets core_done[n] on the next edge; that core's status becomes 11 on the same edge.
  - cycle_count increments every RUN cycle and saturates at all-ones.
  - Transition to DONE occurs when (core_done | end_process) is all ones. Simultaneous completion of several cores in one cycle is legal.
  - Completion has priority over timeout in the same cycle.
  - clear=1 → IDLE (abort); core_done and cycle_count are kept for inspection. Clear has priority over completion and timeout.
- Timeout:
  - If TIMEOUT≠0 and cycle_count == TIMEOUT-1 while RUN with completion not met → ERROR.
  - cycle_count equals TIMEOUT in ERROR.
- DONE:
  - done=1, all status=11, cycle_count frozen.
  - clear=1 → IDLE.
  - start is ignored.
- ERROR:
  - error=1, all status=00, cycle_count and core_done frozen.
  - clear=1 → IDLE.
- Latency:
  - start → status 01 visible after 1 cycle.
  - Last end_process → done after 1 cycle.
- Flag behaviour:
  - end_process is level-sensitive; core_done bits are sticky until the next START entry.
  - end_process high outside RUN is ignored.
- Asynchronous reset mid-run returns immediately to IDLE with status 00. Cores then stop and wait.
- busy, done and error are mutually exclusive; all are 0 in IDLE.

Test Plan (NUM_CORES=2, START_CYCLES=2, TIMEOUT=16 unless noted):
- Normal run: start pulse; end_process[0] at RUN cycle 5, end_process[1] at cycle 9.
  - Status 0101 for 2 cycles, then 1010, then 1011 after core0 finishes.
  - done=1 with status 1111 and cycle_count=10.
  - clear → IDLE, status 0000.
- Simultaneous finish: both end_process bits high at RUN cycle 3 → done next cycle, core_done=11, cycle_count=4.
- Timeout: no end_process.
  - error=1 after 16 RUN cycles, cycle_count=16, status 0000, busy=0.
  - clear → IDLE.
- Abort and ignored inputs:
  - end_process high during START → ignored, core_done=00.
  - clear at RUN cycle 3 → IDLE, status 0000, cycle_count=3.
  - start while in DONE → ignored.
- Async reset asserted mid-RUN between clock edges → status, busy and cycle_count zero immediately, FSM in IDLE.
- TIMEOUT=0, CYCLE_W=4, end_process after 20 RUN cycles → no error; cycle_count saturates at 15; done=1.
